// File: rtl/pe_result_accum_drain.sv
// rtl/pe_result_accum_drain.sv - lane-wise accumulator for PE array products with row-wise drain stream
//
// Captures the PE array's Mul vector once per pass and sums it lane-wise over
// a variable number of passes. After the pass flagged in_last, the lane sums
// are drained one row (ROW_SIZE lanes) per beat over a valid/ready stream.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     pass handshake; in_last marks the final pass
//   mul_in                ARRAY_SIZE products, lane 0 in the MSBs
//   out_valid/out_ready   drain beat handshake
//   out_data              ROW_SIZE accumulators of row out_row, lowest lane in the MSBs
//   out_row, out_last     row index of the beat, high on the final row
//   busy                  high while accumulating or draining
module pe_result_accum_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_SIZE = 128,
    parameter int ROW_SIZE   = 16,
    parameter int ACC_WIDTH  = 32,
    localparam int NUM_ROWS  = ARRAY_SIZE / ROW_SIZE,
    localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] mul_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH*ROW_SIZE-1:0]  out_data,
    output logic [ROW_W-1:0]               out_row,
    output logic                           out_last,
    output logic                           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Accumulators organised by drain row so the output mux indexes by row directly.
    logic [ACC_WIDTH-1:0] acc_q [NUM_ROWS][ROW_SIZE];
    logic [ROW_W-1:0]     row_q;

    logic accept;
    logic beat_done;
    logic last_row;

    function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
        return ACC_WIDTH'($signed(v));
    endfunction

    assign in_ready  = (state_q != DRAIN);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid & in_ready;
    assign beat_done = out_valid & out_ready;
    assign last_row  = (row_q == ROW_W'(NUM_ROWS - 1));
    assign out_last  = out_valid & last_row;
    assign out_row   = row_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_done && last_row) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The first pass after IDLE overwrites, so stale sums never need clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < ROW_SIZE; c++) begin
                    acc_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < ROW_SIZE; c++) begin
                    acc_q[r][c] <= ((state_q == IDLE) ? '0 : acc_q[r][c])
                        + sext(mul_in[DATA_WIDTH*(ARRAY_SIZE-(r*ROW_SIZE+c))-1 -: DATA_WIDTH]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
        end else if (accept) begin
            row_q <= '0;
        end else if (beat_done) begin
            row_q <= last_row ? '0 : row_q + ROW_W'(1);
        end
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < ROW_SIZE; c++) begin
            out_data[ACC_WIDTH*(ROW_SIZE-c)-1 -: ACC_WIDTH] = acc_q[row_q][c];
        end
    end

endmodule

// File: tb/tb_pe_result_accum_drain.sv
// tb/tb_pe_result_accum_drain.sv - self-checking bench for pe_result_accum_drain
module tb_pe_result_accum_drain;

    localparam int DW  = 16;
    localparam int AS  = 128;
    localparam int RS  = 16;
    localparam int NR  = AS / RS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_last;
    logic [DW*AS-1:0] mul_in;
    logic             out_ready;

    logic             in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [32*RS-1:0] out_data_a;
    logic [2:0]       out_row_a;

    logic             in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [17*RS-1:0] out_data_b;
    logic [2:0]       out_row_b;

    pe_result_accum_drain #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ROW_SIZE(RS), .ACC_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
        .mul_in(mul_in), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_row(out_row_a), .out_last(out_last_a), .busy(busy_a)
    );

    pe_result_accum_drain #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ROW_SIZE(RS), .ACC_WIDTH(17)) u17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
        .mul_in(mul_in), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_row(out_row_b), .out_last(out_last_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: lane sums as plain 32-bit arithmetic, drain progress
    // as "which row is being offered"; 17-bit results are the low bits.
    logic [31:0] m_acc [AS];
    bit          m_active = 0;
    bit          m_draining = 0;
    int          m_row = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            m_draining = 0;
            m_row = 0;
            for (int j = 0; j < AS; j++) m_acc[j] = 32'd0;
        end else if (in_valid && !m_draining) begin
            for (int j = 0; j < AS; j++) begin
                logic [15:0] l;
                l = mul_in[DW*AS-1-DW*j -: DW];
                m_acc[j] = (m_active ? m_acc[j] : 32'd0) + {{16{l[15]}}, l};
            end
            m_active = 1;
            m_draining = in_last;
            m_row = 0;
        end else if (m_draining && out_ready) begin
            if (m_row == NR - 1) begin
                m_active = 0;
                m_draining = 0;
                m_row = 0;
            end else begin
                m_row++;
            end
        end
    end

    bit started = 0;
    int beats[$];

    always @(negedge clk) begin
        if (started) begin
            logic [32*RS-1:0] e32;
            logic [17*RS-1:0] e17;
            e32 = '0;
            e17 = '0;
            for (int c = 0; c < RS; c++) begin
                e32[32*RS-1-32*c -: 32] = m_acc[m_row*RS+c];
                e17[17*RS-1-17*c -: 17] = m_acc[m_row*RS+c][16:0];
            end
            chk("in_ready", {in_ready_a, in_ready_b}, {2{!m_draining}});
            chk("busy", {busy_a, busy_b}, {2{m_active}});
            chk("out_valid", {out_valid_a, out_valid_b}, {2{m_draining}});
            chk("out_last", {out_last_a, out_last_b}, {2{m_draining && m_row == NR - 1}});
            chk("out_row", {out_row_a, out_row_b}, {2{3'(m_row)}});
            if (m_draining) begin
                chk("out_data32", out_data_a, e32);
                chk("out_data17", out_data_b, e17);
            end
            if (out_valid_a && out_ready) beats.push_back(int'(out_row_a));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int j = 0; j < AS; j++) mul_in[DW*AS-1-DW*j -: DW] = v;
    endtask

    task automatic pass(input logic last);
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
        chk("drain_done", {31'd0, busy_a}, 0);
    endtask

    task automatic chk_beats(input string name);
        chk({name, "_count"}, beats.size(), NR);
        for (int i = 0; i < beats.size() && i < NR; i++) chk({name, "_order"}, beats[i], i);
    endtask

    function automatic logic [31:0] lane32(input int c);
        return out_data_a[32*RS-1-32*c -: 32];
    endfunction

    function automatic logic [16:0] lane17(input int c);
        return out_data_b[17*RS-1-17*c -: 17];
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mul_in = '0; out_ready = 1'b0;
        tick();
        started = 1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_data", out_data_a, 0);
        chk("reset_out_valid", out_valid_a, 0);
        chk("reset_in_ready", in_ready_a, 1);
        chk("reset_busy", busy_a, 0);

        // Single pass of 3, free-running drain.
        out_ready = 1'b1;
        set_all(16'h0003);
        beats.delete();
        pass(1'b1);
        @(negedge clk);
        chk("single_latency_valid", out_valid_a, 1);
        chk("single_lane0", lane32(0), 32'h00000003);
        chk("single_lane15", lane32(15), 32'h00000003);
        wait_idle();
        chk_beats("single_beats");

        // Three passes: j, 2, -1 -> j+1.
        out_ready = 1'b0;
        for (int j = 0; j < AS; j++) mul_in[DW*AS-1-DW*j -: DW] = 16'(j);
        pass(1'b0);
        set_all(16'h0002);
        pass(1'b0);
        set_all(16'hFFFF);
        pass(1'b1);
        @(negedge clk);
        chk("three_model_lane5", m_acc[5], 32'h00000006);
        chk("three_lane5", lane32(5), 32'h00000006);
        chk("three_lane0", lane32(0), 32'h00000001);
        chk("three_lane15", lane32(15), 32'h00000010);
        out_ready = 1'b1;
        wait_idle();

        // Wrap at 17 bits.
        out_ready = 1'b0;
        set_all(16'h7FFF);
        pass(1'b0);
        pass(1'b1);
        @(negedge clk);
        chk("wrap17_pos", lane17(0), 17'h0FFFE);
        chk("wrap32_pos", lane32(0), 32'h0000FFFE);
        out_ready = 1'b1;
        wait_idle();
        out_ready = 1'b0;
        set_all(16'h8000);
        pass(1'b0);
        pass(1'b1);
        @(negedge clk);
        chk("wrap17_neg", lane17(7), 17'h10000);
        chk("wrap32_neg", lane32(7), 32'hFFFF0000);
        out_ready = 1'b1;
        wait_idle();

        // Backpressure at row 2 for 4 cycles.
        for (int j = 0; j < AS; j++) mul_in[DW*AS-1-DW*j -: DW] = 16'(j * 3 + 1);
        beats.delete();
        pass(1'b1);
        tick();
        tick();
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stall_row", out_row_a, 2);
            chk("stall_valid", out_valid_a, 1);
            chk("stall_lane0", lane32(0), 32'd97);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        chk_beats("bp_beats");

        // Drain lockout: new pass held on the input throughout the drain.
        set_all(16'h0010);
        in_valid = 1'b1;
        in_last  = 1'b1;
        tick();
        set_all(16'h0020);
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                chk("lock_in_ready", in_ready_a, 0);
                chk("lock_lane0", lane32(0), 32'h00000010);
                if (out_last_a) seen = 1;
                tick();
            end
            chk("lock_last_seen", {31'd0, seen}, 1);
        end
        @(negedge clk);
        chk("lock_idle_ready", in_ready_a, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("lock_new_valid", out_valid_a, 1);
        chk("lock_new_lane0", lane32(0), 32'h00000020);
        wait_idle();

        // Reset mid-drain after row 3 transfers.
        set_all(16'h0005);
        pass(1'b1);
        repeat (4) tick();
        @(negedge clk);
        chk("rst_pre_row", out_row_a, 4);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        rst = 1'b0;
        set_all(16'h0001);
        pass(1'b1);
        @(negedge clk);
        chk("post_rst_lane0", lane32(0), 32'h00000001);
        chk("post_rst_lane15", lane32(15), 32'h00000001);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
